mem_port_arbiter: RTL and testbench



---
 rtl/mem_port_arbiter_pkg.sv | 19 +
 rtl/mem_port_arbiter_if.sv | 44 ++++
 rtl/mem_port_arbiter_rr_arbiter2.sv | 21 ++
 rtl/mem_port_arbiter.sv | 119 +++++++++++
 tb/tb_mem_port_arbiter.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the memory-port arbiter: FSM states, requester IDs
// and the saturating counter helper.
package arb_defs;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic REQ_IF = 1'b0;
    localparam logic REQ_DM = 1'b1;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the IF/DM request-response ports and the unified memory port.
// slave = arbiter side, master = requesters plus memory side.
interface mem_port_arbiter_if #(
    parameter int AW = 16,
    parameter int DW = 16
);
    logic          if_req_valid;
    logic          if_req_ready;
    logic [AW-1:0] if_addr;
    logic          if_rsp_valid;
    logic [DW-1:0] if_rdata;

    logic          dm_req_valid;
    logic          dm_req_ready;
    logic          dm_we;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata;
    logic          dm_rsp_valid;
    logic [DW-1:0] dm_rdata;

    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  if_req_valid, if_addr,
        output if_req_ready, if_rsp_valid, if_rdata,
        input  dm_req_valid, dm_we, dm_addr, dm_wdata,
        output dm_req_ready, dm_rsp_valid, dm_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output if_req_valid, if_addr,
        input  if_req_ready, if_rsp_valid, if_rdata,
        output dm_req_valid, dm_we, dm_addr, dm_wdata,
        input  dm_req_ready, dm_rsp_valid, dm_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/mem_port_arbiter_rr_arbiter2.sv
// Combinational two-way round-robin grant; bit 0 = IF, bit 1 = DM.
// The last_grant pointer is held by the parent.
module rr_arbiter2
    import arb_defs::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    input  logic       enable,
    output logic [1:0] gnt
);
    always_comb begin
        gnt = 2'b00;
        if (enable) begin
            if (req == 2'b11) begin
                gnt = (last_grant == REQ_IF) ? 2'b10 : 2'b01;
            end else begin
                gnt = req;
            end
        end
    end
endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin share of one memory port between instruction fetch and data
// access, one transaction in flight. Define ARB_PERF_CNT_EN for grant/conflict counters.
module mem_port_arbiter
    import arb_defs::*;
#(
    parameter int AW      = 16,
    parameter int DW      = 16,
    parameter int MEM_LAT = 1
) (
    input  logic                clk,
    input  logic                rst,
    mem_port_arbiter_if.slave   bus,
`ifdef ARB_PERF_CNT_EN
    output logic [15:0]         if_grant_cnt,
    output logic [15:0]         dm_grant_cnt,
    output logic [15:0]         conflict_cnt,
`endif
    output logic                busy
);
    localparam int CW = $clog2(MEM_LAT + 1);

    state_t        state, state_nxt;
    logic [CW-1:0] cnt;
    logic          last_grant;
    logic          owner;
    logic          op_we;
    logic [1:0]    gnt;
    logic          hs;
    logic          wait_done;

    // Grants only in IDLE and never while reset is held, so ready stays low in reset.
    rr_arbiter2 u_rr (
        .req        ({bus.dm_req_valid, bus.if_req_valid}),
        .last_grant (last_grant),
        .enable     ((state == IDLE) && !rst),
        .gnt        (gnt)
    );

    assign bus.if_req_ready = gnt[0];
    assign bus.dm_req_ready = gnt[1];
    assign hs        = |gnt;
    assign wait_done = (state == WAIT) && (cnt == CW'(1));
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (hs) state_nxt = ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT:    if (wait_done) state_nxt = RESP;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt              <= '0;
            last_grant       <= REQ_DM;
            owner            <= REQ_IF;
            op_we            <= 1'b0;
            bus.mem_en       <= 1'b0;
            bus.mem_we       <= 1'b0;
            bus.mem_addr     <= '0;
            bus.mem_wdata    <= '0;
            bus.if_rsp_valid <= 1'b0;
            bus.if_rdata     <= '0;
            bus.dm_rsp_valid <= 1'b0;
            bus.dm_rdata     <= '0;
        end else begin
            bus.mem_en       <= 1'b0;
            bus.mem_we       <= 1'b0;
            bus.mem_addr     <= '0;
            bus.mem_wdata    <= '0;
            bus.if_rsp_valid <= 1'b0;
            bus.dm_rsp_valid <= 1'b0;
            if (state == IDLE && hs) begin
                owner         <= gnt[1] ? REQ_DM : REQ_IF;
                last_grant    <= gnt[1] ? REQ_DM : REQ_IF;
                op_we         <= gnt[1] & bus.dm_we;
                bus.mem_en    <= 1'b1;
                bus.mem_we    <= gnt[1] & bus.dm_we;
                bus.mem_addr  <= gnt[1] ? bus.dm_addr : bus.if_addr;
                bus.mem_wdata <= gnt[1] ? bus.dm_wdata : '0;
            end
            if (state == ISSUE) cnt <= CW'(MEM_LAT);
            if (state == WAIT)  cnt <= cnt - CW'(1);
            // Read data is valid on the last WAIT cycle; it lands directly in the owner's rdata.
            if (wait_done) begin
                if (owner == REQ_DM) begin
                    bus.dm_rsp_valid <= 1'b1;
                    bus.dm_rdata     <= op_we ? '0 : bus.mem_rdata;
                end else begin
                    bus.if_rsp_valid <= 1'b1;
                    bus.if_rdata     <= bus.mem_rdata;
                end
            end
        end
    end

`ifdef ARB_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if_grant_cnt <= '0;
            dm_grant_cnt <= '0;
            conflict_cnt <= '0;
        end else begin
            if (gnt[0]) if_grant_cnt <= sat_inc16(if_grant_cnt);
            if (gnt[1]) dm_grant_cnt <= sat_inc16(dm_grant_cnt);
            if (state == IDLE && bus.if_req_valid && bus.dm_req_valid)
                conflict_cnt <= sat_inc16(conflict_cnt);
        end
    end
`endif
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with MEM_LAT=2 and a two-stage read memory model.
module tb_mem_port_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy;
    int   checks = 0;
    int   errors = 0;

`ifdef ARB_PERF_CNT_EN
    logic [15:0] if_grant_cnt, dm_grant_cnt, conflict_cnt;
`endif

    mem_port_arbiter_if #(.AW(16), .DW(16)) bus ();

    mem_port_arbiter #(.AW(16), .DW(16), .MEM_LAT(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
`ifdef ARB_PERF_CNT_EN
        .if_grant_cnt (if_grant_cnt),
        .dm_grant_cnt (dm_grant_cnt),
        .conflict_cnt (conflict_cnt),
`endif
        .busy         (busy)
    );

    always #5 clk = ~clk;

    // Memory: data appears two cycles after the mem_en cycle.
    logic [15:0] mem_arr [0:255];
    logic [15:0] rd_p0, rd_p1;
    always_ff @(posedge clk) begin
        rd_p0 <= mem_arr[bus.mem_addr[7:0]];
        rd_p1 <= rd_p0;
    end
    assign bus.mem_rdata = rd_p1;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%04h expected=0x%04h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.if_req_valid = 1'b0;
        bus.dm_req_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        bus.if_req_valid = 1'b0;
        bus.if_addr      = '0;
        bus.dm_req_valid = 1'b0;
        bus.dm_we        = 1'b0;
        bus.dm_addr      = '0;
        bus.dm_wdata     = '0;
        for (int i = 0; i < 256; i++) mem_arr[i] = 16'h0000;
        mem_arr[8'h10] = 16'h1234;
        mem_arr[8'h30] = 16'h5678;

        // Reset state, with both requesters valid during reset
        repeat (2) @(posedge clk);
        #1;
        bus.if_req_valid = 1'b1;
        bus.dm_req_valid = 1'b1;
        #1;
        chk1 ("rst_if_ready", bus.if_req_ready, 1'b0);
        chk1 ("rst_dm_ready", bus.dm_req_ready, 1'b0);
        chk1 ("rst_mem_en",   bus.mem_en,       1'b0);
        chk1 ("rst_busy",     busy,             1'b0);
        chk1 ("rst_if_rsp",   bus.if_rsp_valid, 1'b0);
        chk16("rst_if_rdata", bus.if_rdata,     16'h0000);
        chk16("rst_dm_rdata", bus.dm_rdata,     16'h0000);
        chk16("rst_mem_addr", bus.mem_addr,     16'h0000);
        bus.if_req_valid = 1'b0;
        bus.dm_req_valid = 1'b0;
        tick();
        rst = 1'b0;

        // 1: IF-only read
        bus.if_req_valid = 1'b1;
        bus.if_addr = 16'h0010;
        #1;
        chk1("t1_if_ready", bus.if_req_ready, 1'b1);
        chk1("t1_dm_ready", bus.dm_req_ready, 1'b0);
        tick();
        bus.if_req_valid = 1'b0;
        chk1 ("t1_mem_en",   bus.mem_en,   1'b1);
        chk1 ("t1_mem_we",   bus.mem_we,   1'b0);
        chk16("t1_mem_addr", bus.mem_addr, 16'h0010);
        chk1 ("t1_busy",     busy,         1'b1);
        tick();
        chk1("t1_mem_en_off", bus.mem_en,       1'b0);
        chk1("t1_rsp_early2", bus.if_rsp_valid, 1'b0);
        tick();
        chk1("t1_rsp_early3", bus.if_rsp_valid, 1'b0);
        tick();
        chk1 ("t1_if_rsp",   bus.if_rsp_valid, 1'b1);
        chk16("t1_if_rdata", bus.if_rdata,     16'h1234);
        chk1 ("t1_dm_rsp",   bus.dm_rsp_valid, 1'b0);
        tick();
        chk1("t1_rsp_pulse", bus.if_rsp_valid, 1'b0);
        chk1("t1_idle",      busy,             1'b0);

        // 2: DM write
        bus.dm_req_valid = 1'b1;
        bus.dm_we    = 1'b1;
        bus.dm_addr  = 16'h0020;
        bus.dm_wdata = 16'hBEEF;
        #1;
        chk1("t2_dm_ready", bus.dm_req_ready, 1'b1);
        tick();
        bus.dm_req_valid = 1'b0;
        bus.dm_we = 1'b0;
        chk1 ("t2_mem_en",    bus.mem_en,    1'b1);
        chk1 ("t2_mem_we",    bus.mem_we,    1'b1);
        chk16("t2_mem_addr",  bus.mem_addr,  16'h0020);
        chk16("t2_mem_wdata", bus.mem_wdata, 16'hBEEF);
        repeat (3) tick();
        chk1 ("t2_dm_rsp",      bus.dm_rsp_valid, 1'b1);
        chk16("t2_dm_rdata",    bus.dm_rdata,     16'h0000);
        chk1 ("t2_if_rsp",      bus.if_rsp_valid, 1'b0);
        chk16("t2_if_rdata_hold", bus.if_rdata,   16'h1234);
        tick();

        // 3: both valid continuously -> IF, DM, IF, DM
        do_reset();
        bus.if_addr = 16'h0010;
        bus.dm_addr = 16'h0030;
        bus.dm_we   = 1'b0;
        bus.if_req_valid = 1'b1;
        bus.dm_req_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            logic ev;
            ev = ((k % 2) == 0);
            #1;
            chk1("t3_if_ready", bus.if_req_ready, ev);
            chk1("t3_dm_ready", bus.dm_req_ready, !ev);
            tick();
            chk16("t3_mem_addr", bus.mem_addr, ev ? 16'h0010 : 16'h0030);
            tick();
            chk1("t3_busy_if_ready", bus.if_req_ready, 1'b0);
            chk1("t3_busy_dm_ready", bus.dm_req_ready, 1'b0);
            repeat (2) tick();
            chk1("t3_if_rsp", bus.if_rsp_valid, ev);
            chk1("t3_dm_rsp", bus.dm_rsp_valid, !ev);
            if (ev) chk16("t3_if_rdata", bus.if_rdata, 16'h1234);
            else    chk16("t3_dm_rdata", bus.dm_rdata, 16'h5678);
            tick();
        end
        bus.if_req_valid = 1'b0;
        bus.dm_req_valid = 1'b0;

        // 4: IF only, continuously
        bus.if_req_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk1("t4_if_ready", bus.if_req_ready, 1'b1);
            chk1("t4_dm_ready", bus.dm_req_ready, 1'b0);
            repeat (2) tick();
            chk1("t4_if_ready_busy", bus.if_req_ready, 1'b0);
            repeat (2) tick();
            chk1("t4_if_rsp", bus.if_rsp_valid, 1'b1);
            tick();
        end
        bus.if_req_valid = 1'b0;

        // 5a: reset during WAIT of a DM read
        bus.dm_req_valid = 1'b1;
        bus.dm_addr = 16'h0030;
        #1;
        chk1("t5_dm_ready", bus.dm_req_ready, 1'b1);
        tick();
        bus.dm_req_valid = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        chk1("t5_busy_async", busy,             1'b0);
        chk1("t5_mem_en",     bus.mem_en,       1'b0);
        chk1("t5_dm_rsp",     bus.dm_rsp_valid, 1'b0);
        tick();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk1("t5_no_dm_rsp", bus.dm_rsp_valid, 1'b0);
        end

        // 5b: reset during ISSUE of an IF read, then IF still wins the first tie
        bus.if_req_valid = 1'b1;
        bus.if_addr = 16'h0010;
        #1;
        chk1("t5b_if_ready", bus.if_req_ready, 1'b1);
        tick();
        bus.if_req_valid = 1'b0;
        chk1("t5b_mem_en_issue", bus.mem_en, 1'b1);
        rst = 1'b1;
        #1;
        chk1("t5b_mem_en_drop", bus.mem_en, 1'b0);
        chk1("t5b_busy_drop",   busy,       1'b0);
        tick();
        rst = 1'b0;
        bus.if_req_valid = 1'b1;
        bus.dm_req_valid = 1'b1;
        #1;
        chk1("t5b_tie_if", bus.if_req_ready, 1'b1);
        chk1("t5b_tie_dm", bus.dm_req_ready, 1'b0);
        tick();
        bus.if_req_valid = 1'b0;
        bus.dm_req_valid = 1'b0;
        repeat (3) tick();
        chk1 ("t5b_if_rsp",   bus.if_rsp_valid, 1'b1);
        chk16("t5b_if_rdata", bus.if_rdata,     16'h1234);
        tick();

`ifdef ARB_PERF_CNT_EN
        // 6: performance counters
        do_reset();
        chk16("t6_if_cnt_rst", if_grant_cnt, 16'h0000);
        chk16("t6_cf_cnt_rst", conflict_cnt, 16'h0000);
        bus.if_req_valid = 1'b1;
        bus.dm_req_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            repeat (5) tick();
        end
        bus.if_req_valid = 1'b0;
        bus.dm_req_valid = 1'b0;
        chk16("t6_if_cnt", if_grant_cnt, 16'd2);
        chk16("t6_dm_cnt", dm_grant_cnt, 16'd1);
        chk1 ("t6_cf_cnt", conflict_cnt >= 16'd2, 1'b1);
        force dut.if_grant_cnt = 16'hFFFF;
        #1;
        release dut.if_grant_cnt;
        bus.if_req_valid = 1'b1;
        #1;
        chk1("t6_if_ready", bus.if_req_ready, 1'b1);
        tick();
        bus.if_req_valid = 1'b0;
        chk16("t6_if_sat", if_grant_cnt, 16'hFFFF);
        chk16("t6_dm_keep", dm_grant_cnt, 16'd1);
        repeat (5) tick();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
